// File: rtl/bank_r_clr.sv
// bank_r_clr: DEPTH x DW register file with two combinational read ports, one
// synchronous write port, optional same-cycle write-to-read forwarding and a
// hardware clear sequencer that zeroes every entry after reset or on request.
//
// Parameters:
//   DW     data width in bits
//   AW     address width, DEPTH = 2**AW entries
//   BYPASS 1 = forward same-cycle write data to a matching read port
//
// Ports:
//   clk      rising-edge clock
//   rst_n    synchronous active-low reset (starts a clear sequence)
//   clr      request a full clear (honoured only when not busy)
//   Rw       write enable
//   Dir      write address
//   DIn      write data
//   Rd1/Rd2  read addresses
//   L1/L2    read data (combinational, forced to 0 while busy)
//   busy     high while the clear sequence runs (registered)
//   wr_drop  one-cycle pulse per discarded write (registered)
//
// Optional feature macro: BANK_R_CLR_ZERO_REG_EN
//   When defined, entry 0 reads as zero and writes to address 0 are silently
//   ignored (no wr_drop pulse). The clear sequence still takes DEPTH cycles.
//
// Handshake note: there is no valid/ready pairing here. A write is accepted on
// any rising edge where Rw=1, busy=0 and clr=0; any other Rw=1 edge (busy, or
// colliding with an accepted clr) is discarded and reported on wr_drop in the
// following cycle.

module bank_r_clr #(
  parameter int DW     = 32,
  parameter int AW     = 5,
  parameter int BYPASS = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          Rw,
  input  logic [AW-1:0] Dir,
  input  logic [DW-1:0] DIn,
  input  logic [AW-1:0] Rd1,
  input  logic [AW-1:0] Rd2,
  output logic [DW-1:0] L1,
  output logic [DW-1:0] L2,
  output logic          busy,
  output logic          wr_drop
);

  localparam int DEPTH = 2 ** AW;
  // ptr carries one extra bit so the last-entry test never depends on wrap.
  localparam logic [AW:0] PTR_LAST = (AW + 1)'(DEPTH - 1);
  localparam logic [AW:0] PTR_ONE  = (AW + 1)'(1);

`ifdef BANK_R_CLR_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [AW:0]   ptr;
  logic [AW:0]   ptr_nxt;
  logic          busy_nxt;
  logic          drop_nxt;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          wr_ok;

  logic [DW-1:0] mem [DEPTH];

  // Writes to the hardwired zero entry are filtered out silently.
  assign wr_ok = !(ZERO_REG && (Dir == '0));

  // Next-state and array write port selection.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    busy_nxt  = busy;
    drop_nxt  = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = Dir;
    mem_data  = DIn;
    case (state)
      CLEAR: begin
        // The sequencer owns the write port; any user write is dropped.
        mem_we   = 1'b1;
        mem_addr = ptr[AW-1:0];
        mem_data = '0;
        ptr_nxt  = ptr + PTR_ONE;
        drop_nxt = Rw;
        if (ptr == PTR_LAST) begin
          state_nxt = READY;
          busy_nxt  = 1'b0;
        end
      end
      READY: begin
        if (clr) begin
          state_nxt = CLEAR;
          ptr_nxt   = '0;
          busy_nxt  = 1'b1;
          drop_nxt  = Rw;
        end else if (Rw && wr_ok) begin
          mem_we = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= CLEAR;
      ptr     <= '0;
      busy    <= 1'b1;
      wr_drop <= 1'b0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      busy    <= busy_nxt;
      wr_drop <= drop_nxt;
    end
  end

  // Array has no reset of its own; the clear sequence zeroes it instead, and
  // it is left untouched while rst_n is low.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) begin
      mem[mem_addr] <= mem_data;
    end
  end

  // Read path: stored value, optionally replaced by forwarded write data.
  // busy=1 implies the CLEAR state, so forwarding only ever applies in READY.
  function automatic logic [DW-1:0] read_port(input logic [AW-1:0] ra);
    logic [DW-1:0] v;
    v = mem[ra];
    if ((BYPASS != 0) && Rw && !clr && wr_ok && (ra == Dir)) begin
      v = DIn;
    end
    if (ZERO_REG && (ra == '0)) begin
      v = '0;
    end
    if (busy) begin
      v = '0;
    end
    return v;
  endfunction

  assign L1 = read_port(Rd1);
  assign L2 = read_port(Rd2);

endmodule

// File: tb/tb_bank_r_clr.sv
// Testbench for bank_r_clr. Two instances (forwarding on and off) share the
// same stimulus. A driver applies one input vector per cycle, pushes the
// reference model's expected outputs into one queue per instance, then
// advances the model across the coming clock edge. A monitor pops and compares
// on every falling edge.

module tb_bank_r_clr;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 2 ** AW;
  localparam int W     = 2 * DW + 2;

`ifdef BANK_R_CLR_ZERO_REG_EN
  localparam bit ZERO_EN = 1'b1;
`else
  localparam bit ZERO_EN = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b0;
  logic          clr   = 1'b0;
  logic          rw    = 1'b0;
  logic [AW-1:0] dir   = '0;
  logic [DW-1:0] din   = '0;
  logic [AW-1:0] rd1   = '0;
  logic [AW-1:0] rd2   = '0;

  logic [DW-1:0] l1_b, l2_b, l1_n, l2_n;
  logic          busy_b, drop_b, busy_n, drop_n;

  bank_r_clr #(.DW(DW), .AW(AW), .BYPASS(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .Rw(rw), .Dir(dir), .DIn(din),
    .Rd1(rd1), .Rd2(rd2), .L1(l1_b), .L2(l2_b), .busy(busy_b), .wr_drop(drop_b)
  );

  bank_r_clr #(.DW(DW), .AW(AW), .BYPASS(0)) dut_n (
    .clk(clk), .rst_n(rst_n), .clr(clr), .Rw(rw), .Dir(dir), .DIn(din),
    .Rd1(rd1), .Rd2(rd2), .L1(l1_n), .L2(l2_n), .busy(busy_n), .wr_drop(drop_n)
  );

  // reference model: register contents, clear cycles left, pending drop flag
  logic [DW-1:0] mem_m [DEPTH];
  int            clear_left = DEPTH;
  logic          drop_m     = 1'b0;

  logic [W-1:0] exp_q_b[$];
  logic [W-1:0] exp_q_n[$];

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  function automatic logic [DW-1:0] model_read(input bit byp, input logic [AW-1:0] ra);
    if (clear_left > 0) return '0;
    if (ZERO_EN && ra == '0) return '0;
    if (byp && rw && !clr && ra == dir) return din;
    return mem_m[ra];
  endfunction

  function automatic logic [W-1:0] model_out(input bit byp);
    return {clear_left > 0, drop_m, model_read(byp, rd1), model_read(byp, rd2)};
  endfunction

  // Advance the model across one rising edge using the current inputs.
  task automatic model_edge();
    if (!rst_n) begin
      clear_left = DEPTH;
      drop_m     = 1'b0;
    end else if (clear_left > 0) begin
      drop_m     = rw;
      clear_left = clear_left - 1;
      if (clear_left == 0) begin
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
      end
    end else if (clr) begin
      drop_m     = rw;
      clear_left = DEPTH;
    end else begin
      drop_m = 1'b0;
      if (rw && !(ZERO_EN && dir == '0)) mem_m[dir] = din;
    end
  endtask

  // driver
  task automatic step(input logic r, input logic c, input logic w,
                      input logic [AW-1:0] d, input logic [DW-1:0] di,
                      input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    @(posedge clk);
    #1;
    rst_n = r; clr = c; rw = w; dir = d; din = di; rd1 = a1; rd2 = a2;
    exp_q_b.push_back(model_out(1'b1));
    exp_q_n.push_back(model_out(1'b0));
    model_edge();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b0, 1'b0, AW'($urandom_range(0, DEPTH - 1)), $urandom,
           AW'($urandom_range(0, DEPTH - 1)), AW'($urandom_range(0, DEPTH - 1)));
    end
  endtask

  task automatic read_all();
    for (int i = 0; i < DEPTH / 2; i++) begin
      step(1'b1, 1'b0, 1'b0, '0, '0, AW'(2 * i), AW'(2 * i + 1));
    end
  endtask

  // scoreboard monitor
  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got busy=%b drop=%b L1=%h L2=%h, expected busy=%b drop=%b L1=%h L2=%h",
               name, cyc, got[W-1], got[W-2], got[2*DW-1:DW], got[DW-1:0],
               exp[W-1], exp[W-2], exp[2*DW-1:DW], exp[DW-1:0]);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (exp_q_b.size() > 0) check("bypass_on", {busy_b, drop_b, l1_b, l2_b}, exp_q_b.pop_front());
    if (exp_q_n.size() > 0) check("bypass_off", {busy_n, drop_n, l1_n, l2_n}, exp_q_n.pop_front());
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;

    // reset held two cycles, then the full clear and a sweep of all entries
    step(1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
    step(1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
    idle(DEPTH + 2);
    read_all();

    // write then read, same cycle (forwarding visible on dut_b only) and next
    step(1'b1, 1'b0, 1'b1, AW'(7), 32'hDEADBEEF, AW'(7), AW'(7));
    step(1'b1, 1'b0, 1'b0, '0, '0, AW'(7), AW'(7));

    // write during clear cycle 10 is dropped
    step(1'b1, 1'b1, 1'b0, '0, '0, AW'(7), '0);
    idle(9);
    step(1'b1, 1'b0, 1'b1, AW'(3), 32'h12345678, AW'(3), AW'(7));
    idle(DEPTH - 8);
    step(1'b1, 1'b0, 1'b0, '0, '0, AW'(3), AW'(7));

    // clr colliding with a write
    step(1'b1, 1'b0, 1'b1, AW'(4), 32'hA5A5A5A5, AW'(4), AW'(5));
    step(1'b1, 1'b0, 1'b0, '0, '0, AW'(4), AW'(5));
    step(1'b1, 1'b1, 1'b1, AW'(5), 32'h5A5A5A5A, AW'(4), AW'(5));
    idle(DEPTH + 1);
    step(1'b1, 1'b0, 1'b0, '0, '0, AW'(4), AW'(5));

    // reset in the middle of a clear restarts the full sequence
    step(1'b1, 1'b0, 1'b1, AW'(9), 32'h0BADF00D, AW'(9), AW'(1));
    step(1'b1, 1'b1, 1'b0, '0, '0, AW'(9), '0);
    idle(19);
    step(1'b0, 1'b0, 1'b1, AW'(9), 32'h11111111, AW'(9), '0);
    idle(DEPTH + 1);
    read_all();

    // address 0 write (hardwired zero when the feature macro is defined)
    step(1'b1, 1'b0, 1'b1, '0, 32'hFFFFFFFF, '0, AW'(1));
    step(1'b1, 1'b0, 1'b0, '0, '0, '0, AW'(1));

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [AW-1:0] d;
      d = AW'($urandom_range(0, DEPTH - 1));
      step(($urandom_range(0, 199) != 0), ($urandom_range(0, 49) == 0),
           $urandom_range(0, 1) == 1, d, $urandom,
           ($urandom_range(0, 1) == 1) ? d : AW'($urandom_range(0, DEPTH - 1)),
           ($urandom_range(0, 1) == 1) ? d : AW'($urandom_range(0, DEPTH - 1)));
    end

    // drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 10 && (exp_q_b.size() + exp_q_n.size()) > 0; i++) @(posedge clk);
    if ((exp_q_b.size() + exp_q_n.size()) > 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q_b.size() + exp_q_n.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bank_r_clr.md
# bank_r_clr

Parametrised, clocked successor to the combinational register bank: a DEPTH×DW register file with two asynchronous read ports, one synchronous write port, optional same-cycle write-to-read forwarding, and a hardware clear sequencer. The sequencer zeroes every entry after reset or on request. The block sits in the datapath register stage, between instruction decode (read/write addresses) and write-back (write data).

## Interface
Parameters:
- DW, 32, data width in bits
- AW, 5, address width; DEPTH = 2**AW entries
- BYPASS, 1, 1 = forward same-cycle write data to matching read port; 0 = read returns stored value only

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- clr  in  1  request full clear (sampled in READY only)
- Rw  in  1  write enable
- Dir  in  AW  write address
- DIn  in  DW  write data
- Rd1  in  AW  read address, port 1
- Rd2  in  AW  read address, port 2
- L1  out  DW  read data, port 1 (combinational)
- L2  out  DW  read data, port 2 (combinational)
- busy  out  1  high while clear sequence runs (registered)
- wr_drop  out  1  one-cycle pulse: a write was discarded (registered)

## Operation
- FSM states: CLEAR, READY.
- Reset: rst_n low at a rising edge sets state=CLEAR, ptr=0, busy=1, wr_drop=0. The array is not written while rst_n is low.
- CLEAR: on each edge, mem[ptr] <= 0 and ptr <= ptr+1. The edge that writes ptr=DEPTH-1 moves to READY and drops busy to 0. ptr is AW+1 bits wide so terminal detection does not rely on wrap. clr is ignored in CLEAR.
- READY, clr=1: go to CLEAR with ptr=0 and busy=1. A concurrent Rw is discarded and wr_drop pulses.
- READY, clr=0, Rw=1: mem[Dir] <= DIn.
- CLEAR with Rw=1: the write is discarded and wr_drop=1 on the next cycle.
- Reads:
  - busy=1: L1=L2=0.
  - Otherwise Lx = mem[Rdx].
  - With BYPASS=1, Rw=1, clr=0 and Rdx==Dir, Lx = DIn instead (the write is then effective).
- Both ports may read the same address; no conflict.
- No arithmetic on data; addresses are used unsigned at full AW width; no out-of-range addresses exist.

## Timing
- Write latency: one edge. Without bypass, data is visible on L1/L2 in the cycle after the write edge. With BYPASS=1, data is visible combinationally in the write cycle itself.
- Read latency: zero cycles (combinational from Rd1/Rd2 and the array).
- Clear duration: exactly DEPTH edges with rst_n high after reset release or clr acceptance. busy is high for those DEPTH cycles; the first non-dropped write edge is edge DEPTH+1.
- Reset mid-clear: restarts at ptr=0. The full DEPTH cycles apply again.
- Reset mid-operation: the array contents present at reset are overwritten by the following clear. There is no partial retention.
- Output reset values: busy=1, wr_drop=0, L1=L2=0 (forced by busy).
- wr_drop is high for exactly one cycle per discarded write; back-to-back discarded writes hold it high continuously.

## Configuration
- Macro BANK_R_CLR_ZERO_REG_EN.
- Defined:
  - Entry 0 is hardwired to zero.
  - Writes with Dir=0 are silently discarded. wr_drop does not pulse.
  - Reads of address 0 return 0, including under bypass.
  - The clear sequence still takes DEPTH cycles.
- Undefined: entry 0 is an ordinary register.

## Test plan
- Reset then clear: hold rst_n=0 for 2 cycles, release -> busy=1 for exactly 32 cycles (AW=5), then 0. All 32 entries read back 0x00000000.
- Write/read: write 0xDEADBEEF to addr 7, next cycle Rd1=7, Rd2=7 -> L1=L2=0xDEADBEEF. With BYPASS=1, the same values appear in the write cycle itself; with BYPASS=0, the old value (0) appears in the write cycle.
- Write during busy: Rw=1, Dir=3, DIn=0x12345678 on clear cycle 10 -> wr_drop=1 next cycle only. After clear, L1(Rd1=3)=0.
- clr with concurrent write: fill addr 4=0xA5A5A5A5, then clr=1 with Rw=1, Dir=5 -> wr_drop pulses, busy=1 for 32 cycles. Afterwards addr 4=0 and addr 5=0.
- Reset mid-clear: assert rst_n=0 at clear cycle 20, release -> busy lasts a fresh 32 cycles. All entries read 0.
- BANK_R_CLR_ZERO_REG_EN defined: write 0xFFFFFFFF to addr 0 -> L1(Rd1=0)=0 in the same cycle and next cycle, and wr_drop=0.
